multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core: steps each instruction through fetch, decode, execute, memory and write-back, driving the enables of the instruction register, PC, register file and memories. It consumes the decoded `opcode` from the instruction decoder and the branch comparator result. It enforces memory ready handshakes with timeout and counts retired instructions.

---
 rtl/multicycle_ctrl_pkg.sv | 67 ++++++
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/multicycle_ctrl_wait_timer.sv | 37 +++
 rtl/multicycle_ctrl.sv | 157 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
// The opcode constants are also used by the instruction decoder.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } trap_cause_e;

  // Opcode class latched in DECODE; drives all later per-state decisions.
  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_LUI,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_R:      return CLS_R;
      OPC_I:      return CLS_I;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_JAL:    return CLS_JAL;
      OPC_LUI:    return CLS_LUI;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the sequencer (master) and the datapath/memories (slave).
interface multicycle_ctrl_if #(
  parameter int unsigned N = 32
);
  logic [6:0]   opcode;
  logic         branch_taken;
  logic         imem_ready;
  logic         dmem_ready;
  logic         imem_req;
  logic         ir_we;
  logic         dmem_req;
  logic         dmem_we;
  logic         rf_we;
  logic [1:0]   wb_sel;
  logic         pc_we;
  logic [1:0]   pc_sel;
  logic         trap;
  logic [1:0]   trap_cause;
  logic [N-1:0] instret;

  modport master (
    input  opcode, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
           pc_we, pc_sel, trap, trap_cause, instret
  );

  modport slave (
    output opcode, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
           pc_we, pc_sel, trap, trap_cause, instret
  );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory wait timer shared by FETCH and MEM. Counts ready-low cycles and
// flags the last permitted cycle; TIMEOUT = 0 never expires.
module ctrl_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise advance and saturate at the last cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Count holds the number of low cycles already seen, so LAST marks the
  // TIMEOUT-th cycle of the waiting state.
  assign expired_o = (TIMEOUT != 0) && (count_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP,
// memory-ready timeouts and a retired-instruction counter.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  state_e      state_q, state_d;
  op_class_e   cls_q, cls_d;
  trap_cause_e cause_q, cause_d;
  logic [N-1:0] instret_q;

  logic    retire;
  logic    imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap;
  wb_sel_e wb_sel;
  pc_sel_e pc_sel;

  logic wait_active, wait_ready, wait_expired;

  assign wait_active = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wait_ready  = (state_q == S_FETCH) ? bus.imem_ready : bus.dmem_ready;

  // Held at zero outside FETCH/MEM and on the completing cycle, so every
  // entry into a waiting state starts from zero.
  ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (!wait_active || wait_ready),
    .count_en_i (wait_active && !wait_ready),
    .expired_o  (wait_expired)
  );

  // Next state and per-state control outputs.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cls_d    = cls_q;
    cause_d  = cause_q;
    retire   = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    trap     = 1'b0;
    wb_sel   = WB_ALU;
    pc_sel   = PC_PLUS4;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end

      S_DECODE: begin
        cls_d = classify(bus.opcode);
        if (cls_d == CLS_ILLEGAL) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = bus.branch_taken ? PC_BRANCH : PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (bus.dmem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end

      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        case (cls_q)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL:  wb_sel = WB_PC4;
          CLS_LUI:  wb_sel = WB_IMM;
          default:  wb_sel = WB_ALU;
        endcase
        pc_sel  = (cls_q == CLS_JAL) ? PC_JUMP : PC_PLUS4;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_TRAP: trap = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

  // State, latched class, trap cause and retire counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_ILLEGAL;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
      if (retire) instret_q <= instret_q + N'(1);
    end
  end

  // Everything reads zero while reset is held, even before the first reset edge.
  assign bus.imem_req   = imem_req & ~reset;
  assign bus.ir_we      = ir_we    & ~reset;
  assign bus.dmem_req   = dmem_req & ~reset;
  assign bus.dmem_we    = dmem_we  & ~reset;
  assign bus.rf_we      = rf_we    & ~reset;
  assign bus.pc_we      = pc_we    & ~reset;
  assign bus.trap       = trap     & ~reset;
  assign bus.wb_sel     = reset ? 2'd0 : wb_sel;
  assign bus.pc_sel     = reset ? 2'd0 : pc_sel;
  assign bus.trap_cause = reset ? 2'd0 : cause_q;
  assign bus.instret    = reset ? '0   : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A per-instruction trace model
// builds the expected output vector for every cycle from the instruction
// kind and the chosen memory wait counts, and compares it at the falling edge.
module tb_multicycle_ctrl;

  localparam int unsigned N       = 32;
  localparam int unsigned TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.N(N)) bus ();

  multicycle_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum {K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_LUI, K_BAD} kind_e;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       trap;
    logic [1:0] trap_cause;
  } out_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [N-1:0] m_instret;
  logic [1:0]   m_cause;
  bit           m_trapped;
  string        cur;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic kind_e kind_of(input logic [6:0] opc);
    case (opc)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BRANCH;
      7'b1101111: return K_JAL;
      7'b0110111: return K_LUI;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic out_t observed();
    out_t o;
    o = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.rf_we, bus.wb_sel,
         bus.pc_we, bus.pc_sel, bus.trap, bus.trap_cause};
    return o;
  endfunction

  // One clock: inputs already driven just after the rising edge; compare at the falling edge.
  task automatic step(input out_t e, input string tag);
    @(negedge clk);
    check({tag, " outs"}, observed(), e);
    check({tag, " instret"}, bus.instret, m_instret);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.imem_ready   = 1'($urandom);
    bus.dmem_ready   = 1'($urandom);
    bus.branch_taken = 1'($urandom);
  endtask

  task automatic enter_trap(input logic [1:0] cause);
    m_cause   = cause;
    m_trapped = 1'b1;
  endtask

  task automatic watch_trap(input int cycles);
    out_t e;
    for (int k = 0; k < cycles; k++) begin
      noise();
      bus.opcode = 7'($urandom);
      e = '0;
      e.trap = 1'b1;
      e.trap_cause = m_cause;
      step(e, $sformatf("%s trap k%0d", cur, k));
    end
  endtask

  // Hold reset for a number of cycles with both readies high (a pending
  // completion must still be abandoned), then release it.
  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    m_instret = '0;
    m_cause   = 2'd0;
    m_trapped = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      bus.imem_ready   = 1'b1;
      bus.dmem_ready   = 1'b1;
      bus.branch_taken = 1'($urandom);
      bus.opcode       = 7'($urandom);
      step('0, $sformatf("%s reset k%0d", cur, k));
    end
    reset = 1'b0;
  endtask

  task automatic do_fetch(input int fw, output bit ok);
    out_t e;
    ok = 1'b0;
    for (int c = 0; c <= fw; c++) begin
      noise();
      bus.imem_ready = (c == fw);
      bus.opcode     = 7'($urandom);
      e = '0;
      e.imem_req = 1'b1;
      e.ir_we    = (c == fw);
      step(e, $sformatf("%s fetch c%0d", cur, c));
      if (c == fw) begin
        ok = 1'b1;
        return;
      end
      if (c == int'(TIMEOUT) - 1) begin
        enter_trap(2'd2);
        return;
      end
    end
  endtask

  task automatic do_decode(input logic [6:0] opc, output kind_e k);
    noise();
    bus.opcode = opc;
    step('0, {cur, " decode"});
    k = kind_of(opc);
    if (k == K_BAD) enter_trap(2'd1);
  endtask

  task automatic do_exec(input kind_e k, input logic taken);
    out_t e;
    noise();
    bus.branch_taken = taken;
    e = '0;
    if (k == K_BRANCH) begin
      e.pc_we  = 1'b1;
      e.pc_sel = taken ? 2'd1 : 2'd0;
    end
    step(e, {cur, " exec"});
    if (k == K_BRANCH) m_instret = m_instret + 1'b1;
  endtask

  task automatic do_mem(input kind_e k, input int mw, output bit to_wb);
    out_t e;
    to_wb = 1'b0;
    for (int c = 0; c <= mw; c++) begin
      noise();
      bus.dmem_ready = (c == mw);
      e = '0;
      e.dmem_req = 1'b1;
      e.dmem_we  = (k == K_STORE);
      e.pc_we    = (c == mw) && (k == K_STORE);
      step(e, $sformatf("%s mem c%0d", cur, c));
      if (c == mw) begin
        if (k == K_STORE) m_instret = m_instret + 1'b1;
        else              to_wb = 1'b1;
        return;
      end
      if (c == int'(TIMEOUT) - 1) begin
        enter_trap(2'd3);
        return;
      end
    end
  endtask

  task automatic do_wb(input kind_e k);
    out_t e;
    noise();
    e = '0;
    e.rf_we  = 1'b1;
    e.pc_we  = 1'b1;
    e.wb_sel = (k == K_LOAD) ? 2'd1 : (k == K_JAL) ? 2'd2 : (k == K_LUI) ? 2'd3 : 2'd0;
    e.pc_sel = (k == K_JAL) ? 2'd2 : 2'd0;
    step(e, {cur, " wb"});
    m_instret = m_instret + 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input logic taken);
    bit    ok;
    kind_e k;
    do_fetch(fw, ok);
    if (!ok) return;
    do_decode(opc, k);
    if (k == K_BAD) return;
    do_exec(k, taken);
    if (k == K_BRANCH) return;
    if (k == K_LOAD || k == K_STORE) begin
      do_mem(k, mw, ok);
      if (!ok) return;
    end
    do_wb(k);
  endtask

  logic [6:0] legal_ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110111};

  initial begin
    bit         ok;
    kind_e      k;
    out_t       e;
    logic [6:0] opc;
    int         fw, mw;

    reset = 1'b1;
    bus.opcode = '0;
    bus.branch_taken = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    m_instret = '0;
    m_cause   = '0;
    m_trapped = 1'b0;
    @(posedge clk);
    #1;

    cur = "init";    do_reset(2);
    cur = "add";     run_instr(7'b0110011, 0, 0, 1'b0);
    cur = "load_w2"; run_instr(7'b0000011, 0, 2, 1'b0);
    cur = "store";   run_instr(7'b0100011, 0, 0, 1'b0);
    cur = "beq_t";   run_instr(7'b1100011, 0, 0, 1'b1);
    cur = "beq_nt";  run_instr(7'b1100011, 0, 0, 1'b0);
    cur = "jal";     run_instr(7'b1101111, 1, 0, 1'b0);
    cur = "lui";     run_instr(7'b0110111, 0, 0, 1'b0);
    cur = "addi";    run_instr(7'b0010011, 0, 0, 1'b0);
    cur = "fetch_last_cycle"; run_instr(7'b0110011, int'(TIMEOUT) - 1, 0, 1'b0);
    cur = "mem_last_cycle";   run_instr(7'b0000011, 0, int'(TIMEOUT) - 1, 1'b0);

    cur = "illegal"; run_instr(7'b1111111, 0, 0, 1'b0);
    check("illegal trapped", 64'(m_trapped), 64'd1);
    watch_trap(20);
    do_reset(1);
    cur = "after_illegal"; run_instr(7'b0110011, 0, 0, 1'b0);

    cur = "imem_to"; run_instr(7'b0110011, 1000, 0, 1'b0);
    watch_trap(5);
    do_reset(1);

    cur = "dmem_to"; run_instr(7'b0100011, 0, 1000, 1'b0);
    watch_trap(5);
    do_reset(2);

    // Reset while a store waits in MEM.
    cur = "store_abort";
    do_fetch(0, ok);
    do_decode(7'b0100011, k);
    do_exec(k, 1'b0);
    for (int c = 0; c < 2; c++) begin
      noise();
      bus.dmem_ready = 1'b0;
      e = '0;
      e.dmem_req = 1'b1;
      e.dmem_we  = 1'b1;
      step(e, $sformatf("%s mem c%0d", cur, c));
    end
    do_reset(1);
    cur = "after_abort"; run_instr(7'b0100011, 0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      cur = $sformatf("rnd%0d", i);
      if ($urandom_range(0, 9) == 0) opc = 7'($urandom);
      else                           opc = legal_ops[$urandom_range(0, 6)];
      fw = ($urandom_range(0, 11) == 0) ? int'(TIMEOUT) + 2 : int'($urandom_range(0, TIMEOUT - 1));
      mw = ($urandom_range(0, 11) == 0) ? int'(TIMEOUT) + 2 : int'($urandom_range(0, TIMEOUT - 1));
      run_instr(opc, fw, mw, 1'($urandom));
      if (m_trapped) begin
        watch_trap(3);
        do_reset(int'($urandom_range(1, 3)));
      end
    end

    @(negedge clk);
    check("final instret", bus.instret, m_instret);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
